// File: rtl/val2_pkg.sv
// Shared types and sizes for the Val2 operand-2 shift/rotate arbiter.
package val2_pkg;

    localparam int DW   = 32;
    localparam int NREQ = 2;
    localparam int TW   = 2;
    localparam int AW   = 8;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_type_e;

    // A zero rotate returns the operand directly so no DW-bit left shift is ever built.
    function automatic logic [DW-1:0] ror_dw(input logic [DW-1:0] x, input logic [4:0] r);
        if (r == 5'd0) begin
            return x;
        end
        return (x >> r) | (x << (6'd32 - {1'b0, r}));
    endfunction

endpackage

// File: rtl/val2_shift_core.sv
// Combinational Val2 operand-2 shifter: immediate rotate or register shift, with carry-out.
module val2_shift_core
    import val2_pkg::*;
(
    input  logic          imm,
    input  logic [TW-1:0] sh_type,
    input  logic [AW-1:0] amt,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] result,
    output logic          carry
);

    logic [5:0]           sa;
    logic [4:0]           rot_imm;
    logic [DW-1:0]        imm_val;
    logic [DW:0]          lsl_w;
    logic [DW:0]          lsr_w;
    logic signed [DW:0]   asr_w;

    // Amounts past 32 behave like 32 for the shifts; an extra bit on each side captures the carry.
    assign sa      = (amt > 8'd32) ? 6'd32 : amt[5:0];
    assign rot_imm = {amt[3:0], 1'b0};
    assign imm_val = {{(DW-8){1'b0}}, data[7:0]};
    assign lsl_w   = {1'b0, data} << sa;
    assign lsr_w   = {data, 1'b0} >> sa;
    assign asr_w   = $signed({data, 1'b0}) >>> sa;

    always_comb begin
        result = data;
        carry  = 1'b0;
        if (imm) begin
            result = ror_dw(imm_val, rot_imm);
            carry  = (rot_imm != 5'd0) ? result[DW-1] : 1'b0;
        end else if (amt != 8'd0) begin
            case (shift_type_e'(sh_type))
                SH_LSL: begin
                    result = (amt > 8'd32) ? '0 : lsl_w[DW-1:0];
                    carry  = (amt > 8'd32) ? 1'b0 : lsl_w[DW];
                end
                SH_LSR: begin
                    result = (amt > 8'd32) ? '0 : lsr_w[DW:1];
                    carry  = (amt > 8'd32) ? 1'b0 : lsr_w[0];
                end
                SH_ASR: begin
                    result = asr_w[DW:1];
                    carry  = asr_w[0];
                end
                SH_ROR: begin
                    result = ror_dw(data, amt[4:0]);
                    carry  = result[DW-1];
                end
                default: begin
                    result = data;
                    carry  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/val2_shift_arbiter.sv
// Two-port round-robin arbiter sharing one Val2 shifter, with a single registered result slot.
module val2_shift_arbiter
    import val2_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      in_valid,
    output logic [NREQ-1:0]      in_ready,
    input  logic [NREQ-1:0]      in_imm,
    input  logic [TW*NREQ-1:0]   in_type,
    input  logic [AW*NREQ-1:0]   in_amt,
    input  logic [DW*NREQ-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_id,
    output logic [DW-1:0]        out_data,
    output logic                 out_carry
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high.
    // Input side: ready goes to at most one port and only when the slot is empty or popping;
    // a requester holds its fields stable until it sees ready. Output side: out_* are stable
    // while out_valid & !out_ready.

    logic          rr;
    logic          win;
    logic          slot_free;
    logic          accept;
    logic          sel_imm;
    logic [TW-1:0] sel_type;
    logic [AW-1:0] sel_amt;
    logic [DW-1:0] sel_data;
    logic [DW-1:0] core_result;
    logic          core_carry;

    assign slot_free = !out_valid || out_ready;
    assign win       = (&in_valid) ? rr : in_valid[1];
    assign accept    = rst && slot_free && (|in_valid);

    always_comb begin
        in_ready      = '0;
        in_ready[win] = accept;
    end

    assign sel_imm  = win ? in_imm[1]          : in_imm[0];
    assign sel_type = win ? in_type[TW +: TW]  : in_type[0 +: TW];
    assign sel_amt  = win ? in_amt[AW +: AW]   : in_amt[0 +: AW];
    assign sel_data = win ? in_data[DW +: DW]  : in_data[0 +: DW];

    val2_shift_core u_core (
        .imm     (sel_imm),
        .sh_type (sel_type),
        .amt     (sel_amt),
        .data    (sel_data),
        .result  (core_result),
        .carry   (core_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr        <= 1'b0;
            out_valid <= 1'b0;
            out_id    <= 1'b0;
            out_data  <= '0;
            out_carry <= 1'b0;
        end else if (accept) begin
            rr        <= ~win;
            out_valid <= 1'b1;
            out_id    <= win;
            out_data  <= core_result;
            out_carry <= core_carry;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
